adder_32: RTL and testbench

ADDER_32 -- requirements
Module: adder_32

---
 rtl/adder_32.sv | 63 ++++++
 tb/tb_adder_32.sv | 77 +++++++
 2 files changed

// File: rtl/adder_32.sv
// adder_32: two-level carry-lookahead 32-bit adder with combinational and registered sum/carry/overflow
module adder_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic [WIDTH-1:0] s_q,
  output logic             c_out_q,
  output logic             ovf_q
);
  // Flat sum-of-products carry into position k: ci & p[0..k-1] | OR_j g[j] & p[j+1..k-1]
  function automatic logic la(input logic [7:0] g, input logic [7:0] p, input logic ci, input int k);
    logic r, t;
    r = ci;
    for (int j = 0; j < k; j++) r = r & p[j];
    for (int j = 0; j < k; j++) begin
      t = g[j];
      for (int m = j + 1; m < k; m++) t = t & p[m];
      r = r | t;
    end
    return r;
  endfunction
  logic [WIDTH-1:0] w_g, w_p, w_c;
  logic [7:0]       w_bg, w_bp;
  logic [8:0]       w_bc;
  logic [WIDTH-1:0] r_s;
  logic             r_c, r_o;
  assign w_g = a & b;
  assign w_p = a ^ b;
  for (genvar k = 0; k < 8; k++) begin : g_blk
    for (genvar j = 0; j < 4; j++) begin : g_bit
      assign w_c[4*k+j] = la({4'b0, w_g[4*k+:4]}, {4'b0, w_p[4*k+:4]}, w_bc[k], j);
    end
    assign w_bg[k] = la({4'b0, w_g[4*k+:4]}, {4'b0, w_p[4*k+:4]}, 1'b0, 4);
    assign w_bp[k] = &w_p[4*k+:4];
  end
  for (genvar k = 0; k < 9; k++) begin : g_la2
    assign w_bc[k] = la(w_bg, w_bp, c_in, k);
  end
  assign s     = w_p ^ w_c;
  assign c_out = w_bc[8];
  assign ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= '0;
      r_c <= 1'b0;
      r_o <= 1'b0;
    end else begin
      r_s <= s;
      r_c <= c_out;
      r_o <= ovf;
    end
  end
  assign s_q     = r_s;
  assign c_out_q = r_c;
  assign ovf_q   = r_o;
endmodule

// File: tb/tb_adder_32.sv
// tb_adder_32: directed and random self-check of adder_32 combinational and registered outputs
module tb_adder_32;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, s, s_q;
  logic        c_in, c_out, ovf, c_out_q, ovf_q;
  int          n_vec = 0;
  int          n_err = 0;
  adder_32 dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in),
    .s(s), .c_out(c_out), .ovf(ovf),
    .s_q(s_q), .c_out_q(c_out_q), .ovf_q(ovf_q)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic apply(input string tag, input logic [31:0] va, input logic [31:0] vb, input logic vc,
                       input logic [31:0] es, input logic ec, input logic eo);
    a = va; b = vb; c_in = vc;
    #1;
    check({tag, " s"}, s, es);
    check({tag, " c_out"}, c_out, ec);
    check({tag, " ovf"}, ovf, eo);
    @(posedge clk); #1;
    check({tag, " s_q"}, s_q, es);
    check({tag, " c_out_q"}, c_out_q, ec);
    check({tag, " ovf_q"}, ovf_q, eo);
  endtask
  initial begin
    logic [32:0] ref_sum;
    logic        ref_ovf;
    rst = 1'b1; a = 32'd5; b = 32'd3; c_in = 1'b0;
    #1;
    check("comb under rst", s, 32'd8);
    @(posedge clk); #1;
    check("rst s_q", s_q, 32'd0);
    check("rst c_out_q", c_out_q, 1'b0);
    check("rst ovf_q", ovf_q, 1'b0);
    check("rst comb c_out", c_out, 1'b0);
    rst = 1'b0;
    apply("max_pos",   32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    apply("small",     32'h00000000, 32'h00000010, 1'b0, 32'h00000010, 1'b0, 1'b0);
    apply("all_ones",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    apply("chain",     32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    apply("zero",      32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
    apply("neg_ovf",   32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
    apply("mixed",     32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0);
    apply("blk_carry", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0);
    apply("cin_only",  32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0);
    apply("pre_rst",   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    a = 32'd1; b = 32'd1; c_in = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst s_q", s_q, 32'd0);
    check("mid_rst c_out_q", c_out_q, 1'b0);
    check("mid_rst ovf_q", ovf_q, 1'b0);
    check("mid_rst comb s", s, 32'd2);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst s_q", s_q, 32'd2);
    for (int i = 0; i < 10000; i++) begin
      a = $urandom; b = $urandom; c_in = 1'($urandom_range(1));
      ref_sum = {1'b0, a} + {1'b0, b} + {32'd0, c_in};
      ref_ovf = (a[31] == b[31]) && (ref_sum[31] != a[31]);
      #1;
      check("rnd comb", {ovf, c_out, s}, {ref_ovf, ref_sum});
      @(posedge clk); #1;
      check("rnd reg", {ovf_q, c_out_q, s_q}, {ref_ovf, ref_sum});
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
